// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared types and defaults for the framebuffer rectangle-fill engine.
//
// Contents:
//   FB_WIDTH_DEF / FB_HEIGHT_DEF  default framebuffer geometry (words x rows)
//   FB_DATA_W                     framebuffer word / colour width
//   fb_state_e                    fill engine FSM states
//   color_t                       one framebuffer word
//   fill_cmd_t                    latched fill command
//
// Optional build macro: FB_FILL_PATTERN_EN adds the alternate (checkerboard)
// colour to fill_cmd_t.
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_WIDTH_DEF  = 80;
    localparam int FB_HEIGHT_DEF = 60;
    localparam int FB_DATA_W     = 16;

    typedef logic [FB_DATA_W-1:0] color_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        FILL     = 3'd2,
        NEXT_ROW = 3'd3,
        DONE     = 3'd4
    } fb_state_e;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] w;
        logic [7:0] h;
        color_t     color;
`ifdef FB_FILL_PATTERN_EN
        color_t     color_alt;
`endif
    } fill_cmd_t;

endpackage

// File: rtl/fb_clip.sv
// -----------------------------------------------------------------------------
// fb_clip
// Clips a rectangle (x, y, w, h) against a FB_WIDTH x FB_HEIGHT framebuffer.
// Purely combinational; the parent samples the results in its SETUP state.
//
// Ports:
//   x, y       in   8  rectangle origin (column, row)
//   w, h       in   8  requested width / height
//   w_clip     out  8  min(w, FB_WIDTH-x), or 0 when x is off the right edge
//   h_clip     out  8  min(h, FB_HEIGHT-y), or 0 when y is off the bottom edge
//   zero_area  out  1  clipped rectangle covers no words
// -----------------------------------------------------------------------------
module fb_clip #(
    parameter int FB_WIDTH  = 80,
    parameter int FB_HEIGHT = 60
) (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [7:0] w,
    input  logic [7:0] h,
    output logic [7:0] w_clip,
    output logic [7:0] h_clip,
    output logic       zero_area
);

    // Axis 0 is horizontal, axis 1 is vertical; both follow the same rule.
    logic [15:0] pos_flat;
    logic [15:0] ext_flat;
    logic [15:0] clip_flat;

    assign pos_flat = {y, x};
    assign ext_flat = {h, w};

    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
        localparam int LIM = (gi == 0) ? FB_WIDTH : FB_HEIGHT;

        logic [9:0] pos;
        logic [9:0] ext;
        logic [9:0] room;
        logic [7:0] axis_clip;

        assign pos  = {2'b00, pos_flat[gi*8 +: 8]};
        assign ext  = {2'b00, ext_flat[gi*8 +: 8]};
        // Words/rows left between the origin and the far edge; only
        // meaningful when the origin lies inside the framebuffer.
        assign room = 10'(LIM) - pos;

        always_comb begin
            if (pos >= 10'(LIM)) begin
                axis_clip = '0;
            end else if (ext <= room) begin
                axis_clip = ext[7:0];
            end else begin
                // room < ext <= 255 here, so it fits in 8 bits
                axis_clip = room[7:0];
            end
        end

        assign clip_flat[gi*8 +: 8] = axis_clip;
    end

    assign w_clip    = clip_flat[7:0];
    assign h_clip    = clip_flat[15:8];
    assign zero_area = (w_clip == 8'd0) || (h_clip == 8'd0);

endmodule

// File: rtl/fb_fill_engine.sv
// -----------------------------------------------------------------------------
// fb_fill_engine
// Rectangle-fill writer for the VGA framebuffer BRAM. Accepts one command via
// valid/ready, clips it to the framebuffer and writes one word per clock into
// BRAM port B. Row transitions cost one idle cycle (NEXT_ROW).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cmd_valid/ready command handshake (ready only while IDLE)
//   cmd_x, cmd_y    rectangle origin (column, row)
//   cmd_w, cmd_h    rectangle size in words / rows
//   cmd_color       fill word
//   cmd_color_alt   checkerboard alternate word (FB_FILL_PATTERN_EN only)
//   busy            high in SETUP, FILL and NEXT_ROW
//   done            one-cycle pulse when a command completes
//   bram_web        BRAM write enable (high only in FILL)
//   bram_addrb      BRAM write address
//   bram_dinb       BRAM write data
//
// Optional build macro: FB_FILL_PATTERN_EN -- writes cmd_color where
// (col+row) is even and cmd_color_alt where it is odd.
// All outputs are registered.
// -----------------------------------------------------------------------------
module fb_fill_engine
    import fb_pkg::*;
#(
    parameter int                FB_WIDTH  = FB_WIDTH_DEF,
    parameter int                FB_HEIGHT = FB_HEIGHT_DEF,
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = FB_DATA_W,
    parameter logic [ADDR_W-1:0] FB_BASE   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_x,
    input  logic [7:0]        cmd_y,
    input  logic [7:0]        cmd_w,
    input  logic [7:0]        cmd_h,
    input  logic [DATA_W-1:0] cmd_color,
`ifdef FB_FILL_PATTERN_EN
    input  logic [DATA_W-1:0] cmd_color_alt,
`endif
    output logic              busy,
    output logic              done,
    output logic              bram_web,
    output logic [ADDR_W-1:0] bram_addrb,
    output logic [DATA_W-1:0] bram_dinb
);

    // DATA_W is expected to equal FB_DATA_W (the width of color_t).

    fb_state_e         state_reg,    state_next;
    fill_cmd_t         cmd_reg,      cmd_next;
    logic [7:0]        w_clip_reg,   w_clip_next;
    logic [7:0]        h_clip_reg,   h_clip_next;
    logic [7:0]        col_reg,      col_next;
    logic [7:0]        row_reg,      row_next;
    logic [ADDR_W-1:0] row_base_reg, row_base_next;

    logic              ready_reg,    ready_next;
    logic              busy_reg,     busy_next;
    logic              done_reg,     done_next;
    logic              web_reg,      web_next;
    logic [ADDR_W-1:0] addr_reg,     addr_next;
    logic [DATA_W-1:0] din_reg,      din_next;

    logic [7:0]        clip_w;
    logic [7:0]        clip_h;
    logic              clip_zero;
    logic [31:0]       y_offset;
    logic [ADDR_W-1:0] first_row_base;
    logic [ADDR_W-1:0] x_ext;

    fb_clip #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT)
    ) u_clip (
        .x         (cmd_reg.x),
        .y         (cmd_reg.y),
        .w         (cmd_reg.w),
        .h         (cmd_reg.h),
        .w_clip    (clip_w),
        .h_clip    (clip_h),
        .zero_area (clip_zero)
    );

    // Address of the first word of the top clipped row (modulo 2^ADDR_W).
    assign y_offset       = 32'(cmd_reg.y) * 32'(FB_WIDTH);
    assign first_row_base = FB_BASE + y_offset[ADDR_W-1:0];
    assign x_ext          = ADDR_W'(cmd_reg.x);

    always_comb begin
        state_next    = state_reg;
        cmd_next      = cmd_reg;
        w_clip_next   = w_clip_reg;
        h_clip_next   = h_clip_reg;
        col_next      = col_reg;
        row_next      = row_reg;
        row_base_next = row_base_reg;
        ready_next    = ready_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        web_next      = 1'b0;
        addr_next     = addr_reg;
        din_next      = din_reg;

        unique case (state_reg)
            IDLE: begin
                if (cmd_valid && ready_reg) begin
                    cmd_next.x     = cmd_x;
                    cmd_next.y     = cmd_y;
                    cmd_next.w     = cmd_w;
                    cmd_next.h     = cmd_h;
                    cmd_next.color = cmd_color;
`ifdef FB_FILL_PATTERN_EN
                    cmd_next.color_alt = cmd_color_alt;
`endif
                    state_next = SETUP;
                    ready_next = 1'b0;
                    busy_next  = 1'b1;
                end
            end

            SETUP: begin
                w_clip_next   = clip_w;
                h_clip_next   = clip_h;
                row_base_next = first_row_base;
                col_next      = '0;
                row_next      = '0;
                if (clip_zero) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    // First word is presented in the cycle FILL begins.
                    state_next = FILL;
                    web_next   = 1'b1;
                    addr_next  = first_row_base + x_ext;
                end
            end

            FILL: begin
                if (col_reg == w_clip_reg - 8'd1) begin
                    if (row_reg == h_clip_reg - 8'd1) begin
                        state_next = DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = NEXT_ROW;
                    end
                end else begin
                    col_next  = col_reg + 8'd1;
                    web_next  = 1'b1;
                    addr_next = addr_reg + 1'b1;
                end
            end

            NEXT_ROW: begin
                row_base_next = row_base_reg + ADDR_W'(FB_WIDTH);
                row_next      = row_reg + 8'd1;
                col_next      = '0;
                state_next    = FILL;
                web_next      = 1'b1;
                addr_next     = row_base_reg + ADDR_W'(FB_WIDTH) + x_ext;
            end

            DONE: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end

            default: begin
                state_next = IDLE;
                ready_next = 1'b1;
                busy_next  = 1'b0;
            end
        endcase

        // Data for the word being presented next; col/row are relative to
        // the clipped origin.
        if (web_next) begin
`ifdef FB_FILL_PATTERN_EN
            din_next = (col_next[0] ^ row_next[0]) ? cmd_reg.color_alt : cmd_reg.color;
`else
            din_next = cmd_reg.color;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cmd_reg      <= '0;
            w_clip_reg   <= '0;
            h_clip_reg   <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            row_base_reg <= '0;
            ready_reg    <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            web_reg      <= 1'b0;
            addr_reg     <= '0;
            din_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            cmd_reg      <= cmd_next;
            w_clip_reg   <= w_clip_next;
            h_clip_reg   <= h_clip_next;
            col_reg      <= col_next;
            row_reg      <= row_next;
            row_base_reg <= row_base_next;
            ready_reg    <= ready_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            web_reg      <= web_next;
            addr_reg     <= addr_next;
            din_reg      <= din_next;
        end
    end

    assign cmd_ready  = ready_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign bram_web   = web_reg;
    assign bram_addrb = addr_reg;
    assign bram_dinb  = din_reg;

endmodule

// File: tb/tb_fb_fill_engine.sv
// -----------------------------------------------------------------------------
// tb_fb_fill_engine
// Self-checking bench for fb_fill_engine (default geometry 80x60, base 0).
// Expected BRAM writes are queued before each command and matched in order
// by a write monitor; each scenario task checks timing and status itself.
// Define FB_FILL_PATTERN_EN for both RTL and bench to exercise the
// checkerboard build.
// -----------------------------------------------------------------------------
module tb_fb_fill_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_x = '0;
    logic [7:0]  cmd_y = '0;
    logic [7:0]  cmd_w = '0;
    logic [7:0]  cmd_h = '0;
    logic [15:0] cmd_color = '0;
`ifdef FB_FILL_PATTERN_EN
    logic [15:0] cmd_color_alt = '0;
`endif
    logic        busy;
    logic        done;
    logic        bram_web;
    logic [15:0] bram_addrb;
    logic [15:0] bram_dinb;

    int checks      = 0;
    int failures    = 0;
    int write_count = 0;
    int done_count  = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    always #5 clk = ~clk;

    fb_fill_engine dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_x         (cmd_x),
        .cmd_y         (cmd_y),
        .cmd_w         (cmd_w),
        .cmd_h         (cmd_h),
        .cmd_color     (cmd_color),
`ifdef FB_FILL_PATTERN_EN
        .cmd_color_alt (cmd_color_alt),
`endif
        .busy          (busy),
        .done          (done),
        .bram_web      (bram_web),
        .bram_addrb    (bram_addrb),
        .bram_dinb     (bram_dinb)
    );

    // Write monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (done === 1'b1) done_count++;
        if (bram_web === 1'b1) begin
            write_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                         bram_addrb, bram_dinb);
            end else begin
                mon_e = exp_q.pop_front();
                if (bram_addrb !== mon_e.addr || bram_dinb !== mon_e.data) begin
                    failures++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             bram_addrb, bram_dinb, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic push_write(input int addr, input logic [15:0] data);
        wr_t e;
        e.addr = 16'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drive_cmd(input int x, input int y, input int w, input int h,
                             input logic [15:0] c, input logic [15:0] alt);
        cmd_x     = 8'(x);
        cmd_y     = 8'(y);
        cmd_w     = 8'(w);
        cmd_h     = 8'(h);
        cmd_color = c;
`ifdef FB_FILL_PATTERN_EN
        cmd_color_alt = alt;
`else
        if (alt != c) cmd_color = c;
`endif
    endtask

    // Issue one command (caller is just after a negedge) and check done
    // timing, busy/ready during the command, write count and drain.
    task automatic run_cmd(input string name, input int x, input int y, input int w,
                           input int h, input logic [15:0] c, input logic [15:0] alt,
                           input int exp_done, input int exp_writes);
        int wc0;
        int done_at;
        int status_bad;
        wc0        = write_count;
        done_at    = 0;
        status_bad = 0;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_before: got %b, required 1", name, cmd_ready);
        end
        drive_cmd(x, y, w, h, c, alt);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        drive_cmd(0, 0, 0, 0, 16'hDEAD, 16'hBEEF);
        for (int k = 1; k <= 400 && done_at == 0; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_at = k;
            else if (busy !== 1'b1 || cmd_ready !== 1'b0) status_bad++;
        end
        checks++;
        if (done_at != exp_done) begin
            failures++;
            $display("FAIL %s_done_cycle: got %0d, required %0d (0 = timeout)",
                     name, done_at, exp_done);
        end
        checks++;
        if (status_bad != 0) begin
            failures++;
            $display("FAIL %s_busy_ready: got %0d bad cycles, required 0", name, status_bad);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_at_done: got %b, required 0", name, busy);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s_after_done: got ready=%b done=%b, required ready=1 done=0",
                     name, cmd_ready, done);
        end
        checks++;
        if (write_count - wc0 != exp_writes || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_writes: got %0d writes (%0d pending), required %0d",
                     name, write_count - wc0, exp_q.size(), exp_writes);
        end
        $display("cmd %s x=%0d y=%0d w=%0d h=%0d done_cycle=%0d writes=%0d",
                 name, x, y, w, h, done_at, write_count - wc0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, done, bram_web, bram_addrb, bram_dinb} !== {4'b1000, 16'h0, 16'h0}) begin
            failures++;
            $display("FAIL reset_outputs: got ready=%b busy=%b done=%b web=%b addr=%h din=%h, required 1 0 0 0 0 0",
                     cmd_ready, busy, done, bram_web, bram_addrb, bram_dinb);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        push_write(0,  16'hF00F);
        push_write(1,  16'hF00F);
        push_write(80, 16'hF00F);
        push_write(81, 16'hF00F);
        run_cmd("basic", 0, 0, 2, 2, 16'hF00F, 16'hF00F, 7, 4);
    endtask

    task automatic test_clip();
        push_write(4798, 16'h1234);
        push_write(4799, 16'h1234);
        run_cmd("clip", 78, 59, 5, 3, 16'h1234, 16'h1234, 4, 2);
    endtask

    task automatic test_zero();
        run_cmd("zero_w", 3, 3, 0, 4, 16'h7777, 16'h7777, 2, 0);
        run_cmd("x_out", 80, 3, 4, 4, 16'h7777, 16'h7777, 2, 0);
        run_cmd("y_out", 3, 200, 4, 4, 16'h7777, 16'h7777, 2, 0);
    endtask

    task automatic test_interior();
        // 3x3 block at (10,5): done at 2 + 9 + 2
        logic [15:0] c;
        c = 16'($urandom);
        for (int r = 0; r < 3; r++)
            for (int q = 0; q < 3; q++)
                push_write((5 + r) * 80 + 10 + q, c);
        run_cmd("interior", 10, 5, 3, 3, c, c, 13, 9);
        // Single column clipped at the bottom: rows 57..59 of column 79
        for (int r = 57; r < 60; r++) push_write(r * 80 + 79, 16'hC0DE);
        run_cmd("column", 79, 57, 1, 9, 16'hC0DE, 16'hC0DE, 2 + 3 + 2, 3);
    endtask

    task automatic test_back_to_back();
        int wc0;
        logic exp_ready;
        logic exp_done;
        wc0 = write_count;
        push_write(5 * 80 + 5, 16'hAAAA);
        push_write(7 * 80 + 6, 16'h5555);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_before: got %b, required 1", cmd_ready);
        end
        drive_cmd(5, 5, 1, 1, 16'hAAAA, 16'hAAAA);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 drive_cmd(6, 7, 1, 1, 16'h5555, 16'h5555);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_ready = (k == 4 || k == 8);
            exp_done  = (k == 3 || k == 7);
            checks++;
            if (cmd_ready !== exp_ready || done !== exp_done) begin
                failures++;
                $display("FAIL b2b_cycle%0d: got ready=%b done=%b, required ready=%b done=%b",
                         k, cmd_ready, done, exp_ready, exp_done);
            end
            if (k == 5) cmd_valid = 1'b0;
        end
        checks++;
        if (write_count - wc0 != 2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_writes: got %0d writes (%0d pending), required 2",
                     write_count - wc0, exp_q.size());
        end
        $display("cmd b2b two 1x1 commands writes=%0d", write_count - wc0);
    endtask

    task automatic test_reset_mid_fill();
        int wc0;
        int dc0;
        wc0 = write_count;
        dc0 = done_count;
        for (int q = 0; q < 4; q++) push_write(800 + q, 16'h5A5A);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_ready_before: got %b, required 1", cmd_ready);
        end
        drive_cmd(0, 10, 10, 1, 16'h5A5A, 16'h5A5A);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        // Writes appear in cycles 2..5; the 4th is on the bus at cycle 5.
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, done, bram_web, bram_addrb, bram_dinb} !== {4'b1000, 16'h0, 16'h0}) begin
            failures++;
            $display("FAIL abort_outputs: got ready=%b busy=%b done=%b web=%b addr=%h din=%h, required 1 0 0 0 0 0",
                     cmd_ready, busy, done, bram_web, bram_addrb, bram_dinb);
        end
        checks++;
        if (write_count - wc0 != 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_writes: got %0d writes (%0d pending), required 4",
                     write_count - wc0, exp_q.size());
        end
        checks++;
        if (done_count != dc0) begin
            failures++;
            $display("FAIL abort_done: got %0d done pulses, required 0", done_count - dc0);
        end
        $display("cmd abort x=0 y=10 w=10 h=1 writes=%0d", write_count - wc0);
        rst = 1'b0;
        push_write(3 * 80 + 3, 16'h0F0F);
        run_cmd("after_abort", 3, 3, 1, 1, 16'h0F0F, 16'h0F0F, 3, 1);
    endtask

`ifdef FB_FILL_PATTERN_EN
    task automatic test_pattern();
        push_write(0,  16'hAAAA);
        push_write(1,  16'hBBBB);
        push_write(80, 16'hBBBB);
        push_write(81, 16'hAAAA);
        run_cmd("pattern", 0, 0, 2, 2, 16'hAAAA, 16'hBBBB, 7, 4);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_zero();
        test_interior();
        test_back_to_back();
        test_reset_mid_fill();
`ifdef FB_FILL_PATTERN_EN
        test_pattern();
`endif
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
